hdmi_mode_seq: RTL and testbench



---
 rtl/hdmi_mode_pkg.sv | 37 +++
 rtl/hdmi_mode_sync2.sv | 22 ++
 rtl/hdmi_mode_seq.sv | 248 ++++++++++++++++++++++++
 tb/tb_hdmi_mode_seq.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hdmi_mode_pkg.sv
// Shared types for the HDMI mode sequencer.
// Holds the sequencer state encoding, the per-mode timing record and
// the constant table of the four supported video modes.
package hdmi_mode_pkg;

    localparam int unsigned TIMING_W = 12;

    typedef enum logic [2:0] {
        ST_RUN,
        ST_DRAIN,
        ST_HOLD,
        ST_PLL_RST,
        ST_WAIT_LOCK,
        ST_SETTLE,
        ST_FAULT
    } seq_state_e;

    typedef struct packed {
        logic [TIMING_W-1:0] screen_width;
        logic [TIMING_W-1:0] screen_height;
        logic [TIMING_W-1:0] frame_width;
        logic [TIMING_W-1:0] frame_height;
        logic [TIMING_W-1:0] hsync_start;
        logic [TIMING_W-1:0] hsync_size;
        logic [TIMING_W-1:0] vsync_start;
        logic [TIMING_W-1:0] vsync_size;
    } mode_timing_t;

    // Active, total and sync timing for each selectable mode.
    localparam mode_timing_t MODE_TABLE [4] = '{
        '{12'd640,  12'd480,  12'd800,  12'd525,  12'd16,  12'd96,  12'd10, 12'd2},
        '{12'd800,  12'd600,  12'd1056, 12'd628,  12'd40,  12'd128, 12'd1,  12'd4},
        '{12'd1280, 12'd720,  12'd1650, 12'd750,  12'd110, 12'd40,  12'd5,  12'd5},
        '{12'd2560, 12'd1440, 12'd2720, 12'd1481, 12'd48,  12'd32,  12'd3,  12'd5}
    };

endpackage

// File: rtl/hdmi_mode_sync2.sv
// Two-flop synchroniser for a single asynchronous level.
// Ports: clk_i/rst_i (async active-high), d_i async input, q_o synchronised.
module hdmi_mode_sync2 (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [1:0] sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[0], d_i};
        end
    end

    assign q_o = sync_q[1];

endmodule

// File: rtl/hdmi_mode_seq.sv
// HDMI video-mode sequencer: drains the current frame, holds the encoder in
// reset, switches PLL/timing configuration, pulses PLL reset, waits for a
// settled lock and releases the encoder.
// Ports: clk100/reset (async active-high); mode_valid/mode_id/mode_ready
// request handshake; frame_toggle and pll_locked async inputs; pll_reset,
// mode_sel, hdmi_reset, eight 12-bit timing outputs, busy, lock_err.
// Optional build macro HDMI_MODE_SEQ_LOCK_RETRY_EN: a lock timeout retries
// the PLL reset up to three times before declaring a fault.
module hdmi_mode_seq
    import hdmi_mode_pkg::*;
#(
    parameter int unsigned DEFAULT_MODE   = 0,
    parameter int unsigned PLL_RST_CYCLES = 16,
    parameter int unsigned LOCK_TIMEOUT   = 100000,
    parameter int unsigned SETTLE_CYCLES  = 1024,
    parameter int unsigned DRAIN_TIMEOUT  = 4000000
) (
    input  logic        clk100,
    input  logic        reset,
    input  logic        mode_valid,
    input  logic [1:0]  mode_id,
    output logic        mode_ready,
    input  logic        frame_toggle,
    input  logic        pll_locked,
    output logic        pll_reset,
    output logic [1:0]  mode_sel,
    output logic        hdmi_reset,
    output logic [11:0] screen_width,
    output logic [11:0] screen_height,
    output logic [11:0] frame_width,
    output logic [11:0] frame_height,
    output logic [11:0] hsync_start,
    output logic [11:0] hsync_size,
    output logic [11:0] vsync_start,
    output logic [11:0] vsync_size,
    output logic        busy,
    output logic        lock_err
);

    // One shared counter, sized for the longest limit; it only counts to limit-1.
    localparam int unsigned MAX_A   = (PLL_RST_CYCLES > SETTLE_CYCLES) ? PLL_RST_CYCLES : SETTLE_CYCLES;
    localparam int unsigned MAX_B   = (LOCK_TIMEOUT > DRAIN_TIMEOUT) ? LOCK_TIMEOUT : DRAIN_TIMEOUT;
    localparam int unsigned CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] PLL_LAST    = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DRAIN_LAST  = CNT_W'(DRAIN_TIMEOUT - 1);
    localparam logic [1:0]       DEF_MODE    = 2'(DEFAULT_MODE);

    seq_state_e   state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [1:0]   req_q;
    logic [1:0]   mode_sel_q;
    mode_timing_t timing_q;
    logic         hdmi_reset_q;
    logic         pll_reset_q;
    logic         busy_q;
    logic         mode_ready_q;
    logic         lock_err_q;
    logic         ft_q;
    logic         lock_s;
    logic         ft_s;
    logic         frame_end;
    logic         accept;
`ifdef HDMI_MODE_SEQ_LOCK_RETRY_EN
    logic [1:0]   retry_q;
`endif

    hdmi_mode_sync2 u_sync_lock (
        .clk_i (clk100),
        .rst_i (reset),
        .d_i   (pll_locked),
        .q_o   (lock_s)
    );

    hdmi_mode_sync2 u_sync_frame (
        .clk_i (clk100),
        .rst_i (reset),
        .d_i   (frame_toggle),
        .q_o   (ft_s)
    );

    // Any change of the synchronised toggle marks a frame end.
    always_ff @(posedge clk100 or posedge reset) begin
        if (reset) begin
            ft_q <= 1'b0;
        end else begin
            ft_q <= ft_s;
        end
    end

    assign frame_end = ft_s ^ ft_q;
    assign accept    = mode_valid && mode_ready_q;

    // Sequencer; every output is updated on entry to the state that owns it.
    always_ff @(posedge clk100 or posedge reset) begin
        if (reset) begin
            state_q      <= ST_PLL_RST;
            cnt_q        <= '0;
            req_q        <= DEF_MODE;
            mode_sel_q   <= DEF_MODE;
            timing_q     <= MODE_TABLE[DEF_MODE];
            hdmi_reset_q <= 1'b1;
            pll_reset_q  <= 1'b1;
            busy_q       <= 1'b1;
            mode_ready_q <= 1'b0;
            lock_err_q   <= 1'b0;
`ifdef HDMI_MODE_SEQ_LOCK_RETRY_EN
            retry_q      <= 2'd0;
`endif
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (accept) begin
                        req_q        <= mode_id;
                        mode_ready_q <= 1'b0;
                        busy_q       <= 1'b1;
                        cnt_q        <= '0;
`ifdef HDMI_MODE_SEQ_LOCK_RETRY_EN
                        retry_q      <= 2'd0;
`endif
                        // With lock already gone there is no frame worth draining.
                        if (!lock_s) begin
                            state_q      <= ST_HOLD;
                            hdmi_reset_q <= 1'b1;
                            mode_sel_q   <= mode_id;
                            timing_q     <= MODE_TABLE[mode_id];
                        end else begin
                            state_q <= ST_DRAIN;
                        end
                    end else if (!lock_s) begin
                        state_q      <= ST_PLL_RST;
                        cnt_q        <= '0;
                        hdmi_reset_q <= 1'b1;
                        pll_reset_q  <= 1'b1;
                        busy_q       <= 1'b1;
                        mode_ready_q <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    if (frame_end || (cnt_q == DRAIN_LAST)) begin
                        state_q      <= ST_HOLD;
                        cnt_q        <= '0;
                        hdmi_reset_q <= 1'b1;
                        mode_sel_q   <= req_q;
                        timing_q     <= MODE_TABLE[req_q];
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_HOLD: begin
                    state_q     <= ST_PLL_RST;
                    cnt_q       <= '0;
                    pll_reset_q <= 1'b1;
                end
                ST_PLL_RST: begin
                    if (cnt_q == PLL_LAST) begin
                        state_q     <= ST_WAIT_LOCK;
                        cnt_q       <= '0;
                        pll_reset_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_WAIT_LOCK: begin
                    if (lock_s) begin
                        state_q <= ST_SETTLE;
                        cnt_q   <= '0;
                    end else if (cnt_q == LOCK_LAST) begin
                        cnt_q <= '0;
`ifdef HDMI_MODE_SEQ_LOCK_RETRY_EN
                        if (retry_q != 2'd3) begin
                            retry_q     <= retry_q + 2'd1;
                            state_q     <= ST_PLL_RST;
                            pll_reset_q <= 1'b1;
                        end else begin
                            state_q      <= ST_FAULT;
                            lock_err_q   <= 1'b1;
                            busy_q       <= 1'b0;
                            mode_ready_q <= 1'b1;
                        end
`else
                        state_q      <= ST_FAULT;
                        lock_err_q   <= 1'b1;
                        busy_q       <= 1'b0;
                        mode_ready_q <= 1'b1;
`endif
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_SETTLE: begin
                    if (!lock_s) begin
                        state_q <= ST_WAIT_LOCK;
                        cnt_q   <= '0;
                    end else if (cnt_q == SETTLE_LAST) begin
                        state_q      <= ST_RUN;
                        cnt_q        <= '0;
                        hdmi_reset_q <= 1'b0;
                        busy_q       <= 1'b0;
                        mode_ready_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_FAULT: begin
                    // A fresh request skips the drain: the encoder is already in reset.
                    if (accept) begin
                        state_q      <= ST_HOLD;
                        cnt_q        <= '0;
                        req_q        <= mode_id;
                        mode_sel_q   <= mode_id;
                        timing_q     <= MODE_TABLE[mode_id];
                        lock_err_q   <= 1'b0;
                        busy_q       <= 1'b1;
                        mode_ready_q <= 1'b0;
`ifdef HDMI_MODE_SEQ_LOCK_RETRY_EN
                        retry_q      <= 2'd0;
`endif
                    end
                end
                default: begin
                    state_q     <= ST_PLL_RST;
                    cnt_q       <= '0;
                    pll_reset_q <= 1'b1;
                end
            endcase
        end
    end

    assign mode_ready    = mode_ready_q;
    assign pll_reset     = pll_reset_q;
    assign mode_sel      = mode_sel_q;
    assign hdmi_reset    = hdmi_reset_q;
    assign busy          = busy_q;
    assign lock_err      = lock_err_q;
    assign screen_width  = timing_q.screen_width;
    assign screen_height = timing_q.screen_height;
    assign frame_width   = timing_q.frame_width;
    assign frame_height  = timing_q.frame_height;
    assign hsync_start   = timing_q.hsync_start;
    assign hsync_size    = timing_q.hsync_size;
    assign vsync_start   = timing_q.vsync_start;
    assign vsync_size    = timing_q.vsync_size;

endmodule

// File: tb/tb_hdmi_mode_seq.sv
// Directed bench for hdmi_mode_seq with shortened lock and drain timeouts.
module tb_hdmi_mode_seq;

    localparam int unsigned PLL_RST_CYCLES = 16;
    localparam int unsigned LOCK_TIMEOUT   = 300;
    localparam int unsigned SETTLE_CYCLES  = 1024;
    localparam int unsigned DRAIN_TIMEOUT  = 2000;
    localparam int unsigned BOUND          = 5000;
`ifdef HDMI_MODE_SEQ_LOCK_RETRY_EN
    localparam int unsigned EXP_PULSES = 4;
`else
    localparam int unsigned EXP_PULSES = 1;
`endif
    // Lock edge -> 2 synchroniser flops -> 1 detect cycle -> settle count.
    localparam int unsigned EXP_RELEASE = 3 + SETTLE_CYCLES;

    logic        clk100 = 1'b0;
    logic        reset = 1'b1;
    logic        mode_valid = 1'b0;
    logic [1:0]  mode_id = 2'd0;
    logic        frame_toggle = 1'b0;
    logic        pll_locked = 1'b0;
    logic        mode_ready, pll_reset, hdmi_reset, busy, lock_err;
    logic [1:0]  mode_sel;
    logic [11:0] screen_width, screen_height, frame_width, frame_height;
    logic [11:0] hsync_start, hsync_size, vsync_start, vsync_size;

    int unsigned checks = 0;
    int unsigned errors = 0;

    always #5 clk100 = ~clk100;

    hdmi_mode_seq #(
        .DEFAULT_MODE   (0),
        .PLL_RST_CYCLES (PLL_RST_CYCLES),
        .LOCK_TIMEOUT   (LOCK_TIMEOUT),
        .SETTLE_CYCLES  (SETTLE_CYCLES),
        .DRAIN_TIMEOUT  (DRAIN_TIMEOUT)
    ) dut (
        .clk100        (clk100),
        .reset         (reset),
        .mode_valid    (mode_valid),
        .mode_id       (mode_id),
        .mode_ready    (mode_ready),
        .frame_toggle  (frame_toggle),
        .pll_locked    (pll_locked),
        .pll_reset     (pll_reset),
        .mode_sel      (mode_sel),
        .hdmi_reset    (hdmi_reset),
        .screen_width  (screen_width),
        .screen_height (screen_height),
        .frame_width   (frame_width),
        .frame_height  (frame_height),
        .hsync_start   (hsync_start),
        .hsync_size    (hsync_size),
        .vsync_start   (vsync_start),
        .vsync_size    (vsync_size),
        .busy          (busy),
        .lock_err      (lock_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Negedges until hdmi_reset reaches the given level (bounded).
    task automatic cycles_to_hdmi_reset(input logic level, output int unsigned n);
        n = 0;
        do begin
            @(negedge clk100);
            n++;
        end while (hdmi_reset !== level && n < BOUND);
    endtask

    // Waits (bounded) for pll_reset high, then counts its high cycles.
    task automatic pll_pulse_width(output int unsigned w);
        int unsigned guard = 0;
        while (pll_reset !== 1'b1 && guard < 100) begin
            @(negedge clk100);
            guard++;
        end
        w = 0;
        while (pll_reset === 1'b1 && w < 100) begin
            w++;
            @(negedge clk100);
        end
    endtask

    task automatic wait_run(output logic ok);
        int unsigned n = 0;
        while (busy !== 1'b0 && n < BOUND) begin
            @(negedge clk100);
            n++;
        end
        ok = (busy === 1'b0);
    endtask

    initial begin
        int unsigned n;
        int unsigned pulses;
        int unsigned low_run;
        logic        prev;
        logic        ok;

        // Reset values
        repeat (3) @(negedge clk100);
        chk("rst_hdmi_reset", 32'(hdmi_reset), 1);
        chk("rst_pll_reset", 32'(pll_reset), 1);
        chk("rst_busy", 32'(busy), 1);
        chk("rst_mode_ready", 32'(mode_ready), 0);
        chk("rst_lock_err", 32'(lock_err), 0);
        chk("rst_mode_sel", 32'(mode_sel), 0);
        chk("rst_frame_width", 32'(frame_width), 800);

        // Bring-up: PLL reset pulse, lock 50 cycles later, settle
        reset = 1'b0;
        #1;
        pll_pulse_width(n);
        chk("bringup_pll_pulse", n, PLL_RST_CYCLES);
        repeat (49) @(negedge clk100);
        pll_locked = 1'b1;
        cycles_to_hdmi_reset(1'b0, n);
        chk("bringup_release", n, EXP_RELEASE);
        chk("bringup_frame_width", 32'(frame_width), 800);
        chk("bringup_screen_height", 32'(screen_height), 480);
        chk("bringup_mode_ready", 32'(mode_ready), 1);

        // Switch to mode 3 via frame end
        mode_valid = 1'b1;
        mode_id    = 2'd3;
        @(negedge clk100);
        mode_valid = 1'b0;
        chk("m3_ready_drop", 32'(mode_ready), 0);
        chk("m3_busy", 32'(busy), 1);
        chk("m3_drain_hdmi_reset", 32'(hdmi_reset), 0);
        chk("m3_drain_mode_sel", 32'(mode_sel), 0);
        repeat (500) @(negedge clk100);
        frame_toggle = ~frame_toggle;
        cycles_to_hdmi_reset(1'b1, n);
        chk("m3_frame_to_hold", n, 3);
        chk("m3_hold_mode_sel", 32'(mode_sel), 3);
        chk("m3_hold_frame_width", 32'(frame_width), 2720);
        chk("m3_hold_screen_height", 32'(screen_height), 1440);
        chk("m3_hold_vsync_size", 32'(vsync_size), 5);
        pll_pulse_width(n);
        chk("m3_pll_pulse", n, PLL_RST_CYCLES);
        chk("m3_busy_in_seq", 32'(busy), 1);
        wait_run(ok);
        chk("m3_reached_run", 32'(ok), 1);
        chk("m3_run_hdmi_reset", 32'(hdmi_reset), 0);
        chk("m3_run_screen_width", 32'(screen_width), 2560);

        // Lock lost in RUN, never comes back
        pll_locked = 1'b0;
        cycles_to_hdmi_reset(1'b1, n);
        chk("lost_hdmi_reset_delay", n, 3);
        chk("lost_mode_sel", 32'(mode_sel), 3);
        pulses  = 0;
        low_run = 0;
        prev    = 1'b0;
        n       = 0;
        forever begin
            if (pll_reset && !prev) pulses++;
            low_run = pll_reset ? 0 : low_run + 1;
            prev    = pll_reset;
            if (lock_err === 1'b1 || n >= BOUND) break;
            @(negedge clk100);
            n++;
        end
        chk("fault_lock_err", 32'(lock_err), 1);
        chk("fault_pll_pulses", pulses, EXP_PULSES);
        // low_run includes the sample on which lock_err is first seen
        chk("fault_wait_cycles", low_run, LOCK_TIMEOUT + 1);
        chk("fault_mode_ready", 32'(mode_ready), 1);
        chk("fault_busy", 32'(busy), 0);
        chk("fault_hdmi_reset", 32'(hdmi_reset), 1);

        // Request from FAULT goes straight to HOLD
        mode_valid = 1'b1;
        mode_id    = 2'd1;
        @(negedge clk100);
        mode_valid = 1'b0;
        chk("recover_lock_err", 32'(lock_err), 0);
        chk("recover_mode_sel", 32'(mode_sel), 1);
        chk("recover_frame_width", 32'(frame_width), 1056);
        chk("recover_hsync_size", 32'(hsync_size), 128);
        chk("recover_busy", 32'(busy), 1);

        // Lock glitch at settle count ~700 forces a full settle again
        pll_pulse_width(n);
        chk("recover_pll_pulse", n, PLL_RST_CYCLES);
        pll_locked = 1'b1;
        repeat (703) @(negedge clk100);
        chk("glitch_no_early_release", 32'(hdmi_reset), 1);
        pll_locked = 1'b0;
        repeat (3) @(negedge clk100);
        pll_locked = 1'b1;
        cycles_to_hdmi_reset(1'b0, n);
        chk("glitch_full_settle", n, EXP_RELEASE);
        chk("glitch_mode_sel", 32'(mode_sel), 1);
        chk("glitch_screen_width", 32'(screen_width), 800);

        // Drain timeout with frame_toggle held
        mode_valid = 1'b1;
        mode_id    = 2'd2;
        @(negedge clk100);
        mode_valid = 1'b0;
        n = 1;
        while (mode_sel !== 2'd2 && n < BOUND) begin
            @(negedge clk100);
            n++;
        end
        // one acceptance cycle, then the full drain timeout
        chk("drain_timeout_cycles", n, DRAIN_TIMEOUT + 1);
        chk("drain_frame_width", 32'(frame_width), 1650);
        wait_run(ok);
        chk("drain_reached_run", 32'(ok), 1);
        chk("drain_screen_height", 32'(screen_height), 720);

        // Same-mode request still runs the sequence, then async reset mid-way
        mode_valid = 1'b1;
        mode_id    = 2'd2;
        @(negedge clk100);
        mode_valid = 1'b0;
        chk("resync_busy", 32'(busy), 1);
        frame_toggle = ~frame_toggle;
        cycles_to_hdmi_reset(1'b1, n);
        chk("resync_frame_to_hold", n, 3);
        chk("resync_mode_sel", 32'(mode_sel), 2);
        reset = 1'b1;
        #1;
        chk("midrst_mode_sel", 32'(mode_sel), 0);
        chk("midrst_frame_width", 32'(frame_width), 800);
        chk("midrst_pll_reset", 32'(pll_reset), 1);
        chk("midrst_mode_ready", 32'(mode_ready), 0);
        repeat (2) @(negedge clk100);
        reset = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
